// File: rtl/regfile_dump_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_dump_if : control, regfile read and streaming-output bundle    |
// | for regfile_dump.        Revision: 1.0                                 |
// +----------------------------------------------------------------------+
interface regfile_dump_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   logic          start;
   logic [AW-1:0] first_addr;
   logic [AW-1:0] last_addr;
   logic          busy;
   logic          done;
   logic [AW-1:0] ra1;
   logic [AW-1:0] ra2;
   logic [DW-1:0] rd1;
   logic [DW-1:0] rd2;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_addr;
   logic          out_last;

   modport master (
      output start, first_addr, last_addr, rd1, rd2, out_ready,
      input  busy, done, ra1, ra2, out_valid, out_data, out_addr, out_last
   );

   modport slave (
      input  start, first_addr, last_addr, rd1, rd2, out_ready,
      output busy, done, ra1, ra2, out_valid, out_data, out_addr, out_last
   );
endinterface
`default_nettype wire

// File: rtl/regfile_dump.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_dump : walks a register range two at a time over both read     |
// | ports and streams each word out on valid/ready.                        |
// | Optional trailing XOR checksum word: REGFILE_DUMP_CHECKSUM_EN          |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module regfile_dump #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic          clock,
   input  logic          reset,
   regfile_dump_if.slave bus
);

`ifdef REGFILE_DUMP_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_SEND0 = 3'd2,
      S_SEND1 = 3'd3,
      S_CSUM  = 3'd4,
      S_DONE  = 3'd5
   } state_t;
   localparam bit MARK_LAST = 1'b0;
`else
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_SEND0 = 3'd2,
      S_SEND1 = 3'd3,
      S_DONE  = 3'd5
   } state_t;
   localparam bit MARK_LAST = 1'b1;
`endif

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW-1:0] last_q, last_d;
   logic [DW-1:0] buf1_q, buf1_d;
   logic [AW-1:0] ra1_q, ra1_d;
   logic [AW-1:0] ra2_q, ra2_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic [AW-1:0] out_addr_q, out_addr_d;
   logic          out_last_q, out_last_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
   logic [DW-1:0] csum_q, csum_d;
`endif

   logic          accept;
   logic          finish;
   logic [AW-1:0] ptr_p1;
   logic [AW-1:0] ptr_p2;
   logic [AW-1:0] ptr_p3;

   assign accept = out_valid_q & bus.out_ready;
   assign ptr_p1 = ptr_q + AW'(1);
   assign ptr_p2 = ptr_q + AW'(2);
   assign ptr_p3 = ptr_q + AW'(3);

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      last_d      = last_q;
      buf1_d      = buf1_q;
      ra1_d       = ra1_q;
      ra2_d       = ra2_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      out_last_d  = out_last_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      finish      = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_d      = csum_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               last_d = bus.last_addr;
               if (bus.first_addr > bus.last_addr) begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  ptr_d   = bus.first_addr;
                  ra1_d   = bus.first_addr;
                  // Port 2 never addresses past the end of the range.
                  ra2_d   = (bus.first_addr < bus.last_addr) ?
                            bus.first_addr + AW'(1) : bus.first_addr;
                  busy_d  = 1'b1;
                  state_d = S_FETCH;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                  csum_d  = '0;
`endif
               end
            end
         end

         S_FETCH: begin
            out_valid_d = 1'b1;
            out_data_d  = bus.rd1;
            buf1_d      = bus.rd2;
            out_addr_d  = ptr_q;
            out_last_d  = MARK_LAST && (ptr_q == last_q);
            state_d     = S_SEND0;
         end

         S_SEND0: begin
            if (accept) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
               csum_d = csum_q ^ out_data_q;
`endif
               if (ptr_q == last_q) begin
                  finish = 1'b1;
               end else begin
                  out_data_d = buf1_q;
                  out_addr_d = ptr_p1;
                  out_last_d = MARK_LAST && (ptr_p1 == last_q);
                  state_d    = S_SEND1;
               end
            end
         end

         S_SEND1: begin
            if (accept) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
               csum_d = csum_q ^ out_data_q;
`endif
               if (ptr_p1 == last_q) begin
                  finish = 1'b1;
               end else begin
                  ptr_d       = ptr_p2;
                  ra1_d       = ptr_p2;
                  ra2_d       = (ptr_p2 < last_q) ? ptr_p3 : ptr_p2;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  state_d     = S_FETCH;
               end
            end
         end

`ifdef REGFILE_DUMP_CHECKSUM_EN
         S_CSUM: begin
            if (accept) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               state_d     = S_DONE;
            end
         end
`endif

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (finish) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
         // The running XOR plus the word just accepted is the full checksum.
         out_data_d = csum_q ^ out_data_q;
         out_addr_d = '0;
         out_last_d = 1'b1;
         state_d    = S_CSUM;
`else
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
         busy_d      = 1'b0;
         done_d      = 1'b1;
         state_d     = S_DONE;
`endif
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         last_q      <= '0;
         buf1_q      <= '0;
         ra1_q       <= '0;
         ra2_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         last_q      <= last_d;
         buf1_q      <= buf1_d;
         ra1_q       <= ra1_d;
         ra2_q       <= ra2_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.ra1       = ra1_q;
   assign bus.ra2       = ra2_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_addr  = out_addr_q;
   assign bus.out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_dump : randomized and directed dumps of a modelled regfile  |
// | checked against a queue-based reference.     Revision: 1.0             |
// +----------------------------------------------------------------------+
module tb_regfile_dump;
   localparam int AW = 5;
   localparam int DW = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif
   localparam bit LASTREG = (CS == 0);

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          l;
   } word_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   regfile_dump_if #(.AW(AW), .DW(DW)) bus ();
   regfile_dump #(.AW(AW), .DW(DW)) dut (.clock(clock), .reset(reset), .bus(bus));

   // Register file: combinational read, write on the clock edge, x0 hardwired.
   logic [DW-1:0] rf [32] = '{default: '0};
   logic          we3;
   logic [4:0]    wa3;
   logic [DW-1:0] wd3;
   always @(posedge clock) if (we3 && wa3 != 5'd0) rf[wa3] <= wd3;
   assign bus.rd1 = rf[bus.ra1];
   assign bus.rd2 = rf[bus.ra2];

   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   int    ready_mode;
   int    start_cyc, first_valid_cyc, done_cyc;
   bit    pending, done_seen;
   logic [AW-1:0] fetch_ra1, fetch_ra2;
   word_t exp_q[$];
   word_t got_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   initial forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
         1:       bus.out_ready = ~bus.out_ready;
         2:       bus.out_ready = 1'($urandom_range(0, 1));
         default: bus.out_ready = 1'b1;
      endcase
   end

   // Per-cycle compare against the expected-word queue.
   initial begin : compare
      word_t cur, prev_w;
      bit    stall_prev;
      stall_prev = 1'b0;
      prev_w     = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            stall_prev = 1'b0;
         end else begin
            cur = {bus.out_addr, bus.out_data, bus.out_last};
            if (pending && cyc == start_cyc) begin
               fetch_ra1 = bus.ra1;
               fetch_ra2 = bus.ra2;
            end
            if (stall_prev) begin
               check("stall_valid", 64'(bus.out_valid), 64'd1);
               check("stall_hold", 64'(cur), 64'(prev_w));
            end
            if (bus.out_valid) begin
               if (first_valid_cyc < 0) first_valid_cyc = cyc;
               if (exp_q.size() == 0) check("extra_word", 64'(bus.out_valid), 64'd0);
               else check("word", 64'(cur), 64'(exp_q[0]));
               if (bus.out_ready) begin
                  got_q.push_back(cur);
                  if (exp_q.size() > 0) void'(exp_q.pop_front());
               end
            end
            if (pending && !bus.done && cyc >= start_cyc)
               check("busy", 64'(bus.busy), 64'd1);
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_w     = cur;
            if (bus.done) begin
               check("done_expected", 64'(pending), 64'd1);
               check("done_words_left", 64'(exp_q.size()), 64'd0);
               check("done_busy", 64'(bus.busy), 64'd0);
               check("done_valid", 64'(bus.out_valid), 64'd0);
               pending   = 1'b0;
               done_seen = 1'b1;
               done_cyc  = cyc;
            end
         end
      end
   end

   task automatic wr(input logic [4:0] a, input logic [DW-1:0] d);
      @(posedge clock);
      #1 we3 = 1'b1; wa3 = a; wd3 = d;
      @(posedge clock);
      #1 we3 = 1'b0;
   endtask

   task automatic build_expected(input logic [4:0] f, input logic [4:0] l);
      logic [DW-1:0] x;
      x = '0;
      exp_q.delete();
      got_q.delete();
      if (f <= l) begin
         for (int a = int'(f); a <= int'(l); a++) begin
            exp_q.push_back(word_t'{a[AW-1:0], rf[a], LASTREG && (a == int'(l))});
            x ^= rf[a];
         end
         if (CS != 0) exp_q.push_back(word_t'{'0, x, 1'b1});
      end
   endtask

   // Runs one dump; optionally issues a regfile write landing on the FETCH edge.
   task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input bit noise,
                           input bit wr_en, input logic [4:0] wr_a, input logic [DW-1:0] wr_d,
                           output int k_first, output int k_done);
      build_expected(f, l);
      @(posedge clock);
      #1 bus.start = 1'b1; bus.first_addr = f; bus.last_addr = l;
      @(posedge clock);
      #1 bus.start = 1'b0;
      start_cyc = cyc; first_valid_cyc = -1; done_seen = 1'b0; pending = 1'b1;
      bus.first_addr = 5'($urandom); bus.last_addr = 5'($urandom);
      if (wr_en) begin we3 = 1'b1; wa3 = wr_a; wd3 = wr_d; end
      for (int i = 0; i < 4000 && !done_seen; i++) begin
         @(posedge clock);
         #1 we3 = 1'b0;
         bus.start = noise && !done_seen && ($urandom_range(0, 7) == 0);
      end
      bus.start = 1'b0;
      if (!done_seen) begin
         check("done_timeout", 64'(done_seen), 64'd1);
         pending = 1'b0;
      end
      k_first = (first_valid_cyc < 0) ? -1 : first_valid_cyc - start_cyc + 1;
      k_done  = done_cyc - start_cyc + 1;
   endtask

   task automatic check_zero(input string p);
      check({p, "_ra1"}, 64'(bus.ra1), 64'd0);
      check({p, "_ra2"}, 64'(bus.ra2), 64'd0);
      check({p, "_data"}, 64'(bus.out_data), 64'd0);
      check({p, "_addr"}, 64'(bus.out_addr), 64'd0);
      check({p, "_busy"}, 64'(bus.busy), 64'd0);
      check({p, "_valid"}, 64'(bus.out_valid), 64'd0);
      check({p, "_last"}, 64'(bus.out_last), 64'd0);
      check({p, "_done"}, 64'(bus.done), 64'd0);
   endtask

   initial begin
      int kf, kd, n;
      logic [4:0] f, l;
      bus.start = 1'b0; bus.first_addr = '0; bus.last_addr = '0; bus.out_ready = 1'b1;
      ready_mode = 0; we3 = 1'b0; wa3 = '0; wd3 = '0;
      pending = 1'b0; done_seen = 1'b0; first_valid_cyc = -1; start_cyc = 0; done_cyc = 0;
      #3;
      for (int a = 1; a < 32; a++) wr(a[4:0], $urandom);
      wr(5'd5, 32'h12345678);
      wr(5'd6, 32'h87654321);
      wr(5'd31, 32'h89654321);
      wr(5'd10, 32'h11110000);
      @(negedge clock);
      check_zero("reset");
      #2 reset = 1'b0;

      // Pair 5/6 with latency and literal values.
      run_dump(5'd5, 5'd6, 1'b0, 1'b0, '0, '0, kf, kd);
      check("t1_first_lat", 64'(kf), 64'd2);
      check("t1_done_lat", 64'(kd), 64'(4 + CS));
      check("t1_count", 64'(got_q.size()), 64'(2 + CS));
      if (got_q.size() >= 2) begin
         check("t1_w0", 64'(got_q[0]), 64'({5'd5, 32'h12345678, 1'b0}));
         check("t1_w1", 64'(got_q[1]), 64'({5'd6, 32'h87654321, LASTREG}));
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      if (got_q.size() >= 3) check("t1_csum", 64'(got_q[2]), 64'({5'd0, 32'h95511559, 1'b1}));
`endif

      // Top of the register file.
      run_dump(5'd30, 5'd31, 1'b0, 1'b0, '0, '0, kf, kd);
      check("t2_ra1", 64'(fetch_ra1), 64'd30);
      check("t2_ra2", 64'(fetch_ra2), 64'd31);
      if (got_q.size() >= 2) check("t2_w1", 64'(got_q[1]), 64'({5'd31, 32'h89654321, LASTREG}));

      // Full range with a 1/0 ready pattern.
      ready_mode = 1;
      run_dump(5'd0, 5'd31, 1'b0, 1'b0, '0, '0, kf, kd);
      check("t3_count", 64'(got_q.size()), 64'(32 + CS));
      if (got_q.size() >= 1) check("t3_x0", 64'(got_q[0]), 64'({5'd0, 32'd0, 1'b0}));
      ready_mode = 0;

      // Single word and empty range.
      run_dump(5'd7, 5'd7, 1'b0, 1'b0, '0, '0, kf, kd);
      check("t4_ra2", 64'(fetch_ra2), 64'd7);
      check("t4_count", 64'(got_q.size()), 64'(1 + CS));
      check("t4_done_lat", 64'(kd), 64'(3 + CS));
      run_dump(5'd9, 5'd3, 1'b0, 1'b0, '0, '0, kf, kd);
      check("t5_no_valid", 64'(kf), 64'hFFFF_FFFF_FFFF_FFFF);
      check("t5_done_lat", 64'(kd), 64'd1);

      // Write on the FETCH edge is not seen; the next dump sees it.
      run_dump(5'd10, 5'd11, 1'b0, 1'b1, 5'd10, 32'hDEADBEEF, kf, kd);
      if (got_q.size() >= 1) check("t6_old", 64'(got_q[0]), 64'({5'd10, 32'h11110000, 1'b0}));
      run_dump(5'd10, 5'd10, 1'b0, 1'b0, '0, '0, kf, kd);
      if (got_q.size() >= 1) check("t6_new", 64'(got_q[0]), 64'({5'd10, 32'hDEADBEEF, LASTREG}));

      // Asynchronous reset in the middle of the second word.
      build_expected(5'd5, 5'd6);
      @(posedge clock);
      #1 bus.start = 1'b1; bus.first_addr = 5'd5; bus.last_addr = 5'd6;
      @(posedge clock);
      #1 bus.start = 1'b0; start_cyc = cyc; first_valid_cyc = -1; done_seen = 1'b0; pending = 1'b1;
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      check("t7_in_send1", 64'(bus.out_addr), 64'd6);
      #2 reset = 1'b1; pending = 1'b0; exp_q.delete();
      #1 check_zero("midrst");
      @(negedge clock);
      #2 reset = 1'b0;
      run_dump(5'd5, 5'd6, 1'b0, 1'b0, '0, '0, kf, kd);
      check("t7_after_count", 64'(got_q.size()), 64'(2 + CS));
      check("t7_after_lat", 64'(kd), 64'(4 + CS));

      // Randomized dumps with stray start pulses and varied back-pressure.
      for (int it = 0; it < 25; it++) begin
         wr(5'($urandom_range(1, 31)), $urandom);
         f = 5'($urandom_range(0, 31));
         l = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(int'(f), 31));
         ready_mode = int'($urandom_range(0, 2));
         run_dump(f, l, 1'b1, 1'b0, '0, '0, kf, kd);
         n = (f <= l) ? int'(l) - int'(f) + 1 : 0;
         check("rand_count", 64'(got_q.size()), 64'(n + ((n > 0) ? CS : 0)));
         if (ready_mode == 0)
            check("rand_done_lat", 64'(kd), 64'((n > 0) ? ((n + 1) / 2 + n + 1 + CS) : 1));
         ready_mode = 0;
         repeat (2) @(posedge clock);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
